// File: rtl/xbus_tag_sched.sv
// xbus_tag_sched: allocates per-column tags and locks for the PE array X bus,
// then streams K*NUM_ROW source words onto the bus stamped with (x, y) tags.
module xbus_tag_sched #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned NUM_COL    = 4,
  parameter  int unsigned NUM_ROW    = 2,
  localparam int unsigned TW = ($clog2(NUM_COL) > 1) ? $clog2(NUM_COL) : 1,
  localparam int unsigned RW = ($clog2(NUM_ROW) > 1) ? $clog2(NUM_ROW) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  input  logic                    start,
  input  logic [7:0]              kernel_size,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   bus_data,
  output logic [TW-1:0]           bus_x_tag,
  output logic [RW-1:0]           bus_y_tag,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [NUM_COL*TW-1:0]   tag_out,
  output logic [NUM_COL-1:0]      tag_locks,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned WLW = $clog2(NUM_COL * NUM_ROW + 1);
  localparam int unsigned AW  = TW + 9;

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_STREAM, S_DONE} state_t;

  state_t                      state;
  logic [7:0]                  k_reg;
  logic [TW-1:0]               col_ptr;
  logic [TW-1:0]               mod_cnt;
  logic [TW-1:0]               x_cnt;
  logic [RW-1:0]               y_cnt;
  logic [WLW-1:0]              words_left;
  logic [NUM_COL-1:0][TW-1:0]  tag_mem;

  logic k_legal, lock_c, last_col, mod_wrap, x_wrap, y_wrap, accept, stream_end;

  assign tag_out = tag_mem;

  // Column is locked when its whole group of K columns fits in the array:
  // col_ptr + (K - col_ptr mod K) <= NUM_COL, equivalent to col < K*floor(NUM_COL/K).
  assign k_legal    = (kernel_size != 8'd0) && (32'(kernel_size) <= NUM_COL);
  assign lock_c     = (AW'(col_ptr) + AW'(k_reg) - AW'(mod_cnt)) <= AW'(NUM_COL);
  assign last_col   = (32'(col_ptr) == NUM_COL - 1);
  assign mod_wrap   = (mod_cnt == TW'(k_reg - 8'd1));
  assign x_wrap     = (x_cnt == TW'(k_reg - 8'd1));
  assign y_wrap     = (32'(y_cnt) == NUM_ROW - 1);

  // Source handshake: accept while words remain and the bus slot is free or draining.
  assign in_ready   = (state == S_STREAM) && (words_left != '0) && (!bus_valid || bus_ready);
  assign accept     = in_valid && in_ready;
  assign stream_end = (words_left == '0) && (!bus_valid || bus_ready);

  // Scheduler FSM with registered bus, tag and status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      k_reg      <= '0;
      col_ptr    <= '0;
      mod_cnt    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      words_left <= '0;
      tag_mem    <= '0;
      tag_locks  <= '0;
      bus_data   <= '0;
      bus_x_tag  <= '0;
      bus_y_tag  <= '0;
      bus_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (flush) begin
      state      <= S_IDLE;
      col_ptr    <= '0;
      mod_cnt    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      words_left <= '0;
      tag_locks  <= '0;
      bus_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (k_legal) begin
              k_reg   <= kernel_size;
              col_ptr <= '0;
              mod_cnt <= '0;
              busy    <= 1'b1;
              state   <= S_ALLOC;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_ALLOC: begin
          tag_mem[col_ptr]   <= mod_cnt;
          tag_locks[col_ptr] <= lock_c;
          mod_cnt            <= mod_wrap ? '0 : mod_cnt + TW'(1);
          col_ptr            <= col_ptr + TW'(1);
          if (last_col) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            words_left <= WLW'(k_reg) * WLW'(NUM_ROW);
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (accept) begin
            bus_data   <= in_data;
            bus_x_tag  <= x_cnt;
            bus_y_tag  <= y_cnt;
            bus_valid  <= 1'b1;
            words_left <= words_left - WLW'(1);
            x_cnt      <= x_wrap ? '0 : x_cnt + TW'(1);
            if (x_wrap) y_cnt <= y_wrap ? '0 : y_cnt + RW'(1);
          end else if (bus_ready) begin
            bus_valid <= 1'b0;
          end
          if (stream_end) begin
            done      <= 1'b1;
            tag_locks <= '0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_tag_sched.sv
// Testbench for xbus_tag_sched: scoreboard of expected bus words plus
// per-scenario checks of allocation, streaming, backpressure, flush and reset.
module tb_xbus_tag_sched;

  localparam int unsigned DW = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned NR = 2;
  localparam int unsigned TW = 2;
  localparam int unsigned RW = 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] x;
    logic [RW-1:0] y;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn, flush, start, in_valid, bus_ready;
  logic [7:0]     kernel_size;
  logic [DW-1:0]  in_data;
  logic           in_ready, bus_valid, busy, done, err;
  logic [DW-1:0]  bus_data;
  logic [TW-1:0]  bus_x_tag;
  logic [RW-1:0]  bus_y_tag;
  logic [NC*TW-1:0] tag_out;
  logic [NC-1:0]  tag_locks;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  xbus_tag_sched #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .start(start),
    .kernel_size(kernel_size), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bus_data(bus_data), .bus_x_tag(bus_x_tag),
    .bus_y_tag(bus_y_tag), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .tag_out(tag_out), .tag_locks(tag_locks), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Issue a start with kernel size k; afterwards kernel_size is scrambled.
  task automatic do_start(input int k);
    @(negedge clk);
    start = 1'b1;
    kernel_size = 8'(k);
    @(negedge clk);
    start = 1'b0;
    kernel_size = 8'd1;
    #1;
  endtask

  task automatic check_tags(input int k, input bit locks_expected);
    logic [NC*TW-1:0] et;
    logic [NC-1:0]    el;
    for (int c = 0; c < NC; c++) begin
      et[c*TW +: TW] = TW'(c % k);
      el[c] = locks_expected && (c < k * (NC / k));
    end
    n_cmp++;
    if (tag_out !== et) begin
      n_err++;
      $display("FAIL tag_out k=%0d: got %h want %h", k, tag_out, et);
    end
    n_cmp++;
    if (tag_locks !== el) begin
      n_err++;
      $display("FAIL tag_locks k=%0d: got %b want %b", k, tag_locks, el);
    end
  endtask

  // Start, let allocation run, then check tags at the first STREAM cycle.
  task automatic start_and_alloc(input int k);
    do_start(k);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    repeat (NC) @(negedge clk);
    #1;
    check_tags(k, 1'b1);
  endtask

  // Stream k*NR words; stall bus_ready for stall_len cycles after the first word.
  task automatic run_stream(input int k, input int stall_len);
    int n = k * NR;
    int sent = 0, recv = 0, dones = 0, stall_left = stall_len;
    bit stalled, hs, hs_prev = 1'b0;
    logic [DW-1:0] d0 = '0;
    exp_t e, g;
    for (int cyc = 0; cyc < 100 && dones == 0; cyc++) begin
      @(negedge clk);
      stalled = bus_valid && (stall_left > 0);
      if (stalled) stall_left--;
      bus_ready = !stalled;
      in_valid = (sent < n);
      in_data = 16'($urandom);
      #1;
      if (done) begin
        dones++;
        n_cmp++;
        if (!hs_prev || recv != n) begin
          n_err++;
          $display("FAIL done_timing k=%0d: hs_prev=%0d recv=%0d want 1/%0d", k, hs_prev, recv, n);
        end
      end
      if (stalled) begin
        n_cmp++;
        if ({bus_data, bus_x_tag, bus_y_tag, in_ready} !== {d0, TW'(0), RW'(0), 1'b0}) begin
          n_err++;
          $display("FAIL stall_hold: got d=%h x=%0d y=%0d rdy=%b want d=%h x=0 y=0 rdy=0",
                   bus_data, bus_x_tag, bus_y_tag, in_ready, d0);
        end
      end
      hs = bus_valid && bus_ready;
      if (hs) begin
        g = '{d: bus_data, x: bus_x_tag, y: bus_y_tag};
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL bus_word k=%0d: unexpected word %h, want none", k, bus_data);
        end else begin
          e = sb.pop_front();
          if (g !== e) begin
            n_err++;
            $display("FAIL bus_word k=%0d #%0d: got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                     k, recv, g.d, g.x, g.y, e.d, e.x, e.y);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        if (sent == 0) d0 = in_data;
        sb.push_back('{d: in_data, x: TW'(sent % k), y: RW'((sent / k) % NR)});
        sent++;
      end
      hs_prev = hs;
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL done_seen k=%0d: got %0d pulses want 1 (timeout)", k, dones);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({done, busy, tag_locks} !== {1'b0, 1'b0, NC'(0)} || sb.size() != 0 || recv != n) begin
      n_err++;
      $display("FAIL after_done k=%0d: done=%b busy=%b locks=%b left=%0d recv=%0d want 0/0/0/0/%0d",
               k, done, busy, tag_locks, sb.size(), recv, n);
    end
  endtask

  // Push words until `count` have been accepted (bus_ready held high).
  task automatic send_words(input int count);
    int sent = 0;
    for (int cyc = 0; cyc < 20 && sent < count; cyc++) begin
      @(negedge clk);
      bus_ready = 1'b1;
      in_valid = 1'b1;
      in_data = 16'($urandom);
      #1;
      if (in_ready) sent++;
    end
    n_cmp++;
    if (sent != count) begin
      n_err++;
      $display("FAIL send_words: got %0d want %0d", sent, count);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; start = 1'b0; kernel_size = 8'd0;
    in_data = '0; in_valid = 1'b0; bus_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({in_ready, bus_data, bus_x_tag, bus_y_tag, bus_valid, tag_out, tag_locks, busy, done, err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b d=%h x=%0d y=%0d v=%b tags=%h locks=%b busy=%b done=%b err=%b want all 0",
               in_ready, bus_data, bus_x_tag, bus_y_tag, bus_valid, tag_out, tag_locks, busy, done, err);
    end
    rstn = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, in_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b rdy=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_k2();
    start_and_alloc(2);
    run_stream(2, 0);
  endtask

  task automatic test_k3();
    start_and_alloc(3);
    run_stream(3, 0);
  endtask

  task automatic test_illegal_k(input int k);
    do_start(k);
    n_cmp++;
    if ({err, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL illegal_err k=%0d: err=%b busy=%b want 1 0", k, err, busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({err, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL illegal_after k=%0d: err=%b busy=%b want 0 0", k, err, busy);
    end
    check_tags(3, 1'b0);
  endtask

  task automatic test_back_pressure();
    start_and_alloc(2);
    run_stream(2, 3);
  endtask

  task automatic test_flush();
    start_and_alloc(2);
    send_words(2);
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bus_valid, tag_locks, done, in_ready} !== {1'b0, 1'b0, NC'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL flush_state: busy=%b v=%b locks=%b done=%b rdy=%b want all 0",
               busy, bus_valid, tag_locks, done, in_ready);
    end
    check_tags(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL flush_no_done cycle %0d: done=%b want 0", i, done);
      end
    end
    start_and_alloc(2);
    run_stream(2, 0);
  endtask

  task automatic test_reset_in_stream();
    start_and_alloc(2);
    send_words(1);
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, bus_valid, in_ready, tag_out, tag_locks} !== '0) begin
      n_err++;
      $display("FAIL reset_in_stream: busy=%b v=%b rdy=%b tags=%h locks=%b want all 0",
               busy, bus_valid, in_ready, tag_out, tag_locks);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_k2();
    test_k3();
    test_illegal_k(5);
    test_illegal_k(0);
    test_back_pressure();
    test_flush();
    test_reset_in_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
